// File: rtl/sma_price_ring_buffer.sv
// Per-stock circular price window for the SMA path: writes each price at the stock's head and returns the evicted one.
// Define SMA_BUF_FLUSH_EN to make i_flush clear a stock's head and count; otherwise i_flush is ignored.
module sma_price_ring_buffer #(
  parameter int unsigned NUM_STOCKS  = 4,
  parameter int unsigned BUFFER_SIZE = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE),
  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [SID_W-1:0]      i_stock_id,
  input  logic [DATA_WIDTH-1:0] i_price,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [SID_W-1:0]      o_stock_id,
  output logic [DATA_WIDTH-1:0] o_incoming_price,
  output logic [DATA_WIDTH-1:0] o_outgoing_price,
  output logic                  o_window_full,
  output logic [CNT_W-1:0]      o_count
);

  localparam int unsigned DEPTH  = NUM_STOCKS * BUFFER_SIZE;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BUFFER_SIZE);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     init_addr_q;
  logic [PTR_W-1:0]      head_q [NUM_STOCKS];
  logic [CNT_W-1:0]      cnt_q  [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] mem    [DEPTH];

  logic                  flush_c, accept_c, mem_we_c;
  logic [ADDR_W-1:0]     mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c, rd_data_c;
  logic [PTR_W-1:0]      cur_head_c;
  logic [CNT_W-1:0]      cur_cnt_c, nxt_cnt_c;

`ifdef SMA_BUF_FLUSH_EN
  assign flush_c = i_flush & o_ready;
`else
  logic unused_flush;
  assign unused_flush = i_flush;
  assign flush_c      = 1'b0;
`endif

  assign accept_c   = i_valid & o_ready & ~flush_c;
  assign cur_head_c = head_q[i_stock_id];
  assign cur_cnt_c  = cnt_q[i_stock_id];
  assign nxt_cnt_c  = (cur_cnt_c == FULL_CNT) ? FULL_CNT : cur_cnt_c + CNT_W'(1);
  assign rd_data_c  = mem[mem_addr_c];

  // Init sweeps the whole array once; after that the FSM stays in run until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_addr_q == LAST_ADDR) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Single memory port: zero-fill during init, otherwise the accepted price at the head slot.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = ADDR_W'({i_stock_id, cur_head_c});
    mem_wdata_c = i_price;
    if (state_q == S_INIT) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = init_addr_q;
      mem_wdata_c = '0;
    end else if (accept_c) begin
      mem_we_c = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      o_ready     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_ready <= (state_d == S_RUN);
      if (state_q == S_INIT) init_addr_q <= init_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_STOCKS; i++) begin
        head_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else if (flush_c) begin
      head_q[i_stock_id] <= '0;
      cnt_q[i_stock_id]  <= '0;
    end else if (accept_c) begin
      head_q[i_stock_id] <= cur_head_c + PTR_W'(1);
      cnt_q[i_stock_id]  <= nxt_cnt_c;
    end
  end

  // Result fields update only on accept and hold between pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid          <= 1'b0;
      o_stock_id       <= '0;
      o_incoming_price <= '0;
      o_outgoing_price <= '0;
      o_window_full    <= 1'b0;
      o_count          <= '0;
    end else begin
      o_valid <= accept_c;
      if (accept_c) begin
        o_stock_id       <= i_stock_id;
        o_incoming_price <= i_price;
        o_outgoing_price <= (cur_cnt_c == FULL_CNT) ? rd_data_c : '0;
        o_window_full    <= (nxt_cnt_c == FULL_CNT);
        o_count          <= nxt_cnt_c;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
  end

endmodule

// File: tb/tb_sma_price_ring_buffer.sv
// Bench for sma_price_ring_buffer: directed and random prices checked against a per-stock price-history model.
// Honours SMA_BUF_FLUSH_EN the same way as the design.
module tb_sma_price_ring_buffer;

  localparam int NS = 4;
  localparam int B  = 4;
`ifdef SMA_BUF_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic [1:0]  i_stock_id = '0;
  logic [31:0] i_price = '0;
  logic        o_ready, o_valid, o_window_full;
  logic [1:0]  o_stock_id;
  logic [31:0] o_incoming_price, o_outgoing_price;
  logic [2:0]  o_count;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  // Model: the prices each stock's window currently holds, oldest first.
  logic [31:0] hist [NS][$];
  logic        e_valid;
  logic [1:0]  e_sid;
  logic [31:0] e_in, e_out;
  logic        e_full;
  logic [2:0]  e_cnt;

  sma_price_ring_buffer #(.NUM_STOCKS(NS), .BUFFER_SIZE(B), .DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_stock_id(i_stock_id), .i_price(i_price), .o_ready(o_ready), .o_valid(o_valid),
    .o_stock_id(o_stock_id), .o_incoming_price(o_incoming_price),
    .o_outgoing_price(o_outgoing_price), .o_window_full(o_window_full), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready"}, 64'(o_ready), 0);
    chk({pfx, "_valid"}, 64'(o_valid), 0);
    chk({pfx, "_sid"},   64'(o_stock_id), 0);
    chk({pfx, "_in"},    64'(o_incoming_price), 0);
    chk({pfx, "_out"},   64'(o_outgoing_price), 0);
    chk({pfx, "_full"},  64'(o_window_full), 0);
    chk({pfx, "_cnt"},   64'(o_count), 0);
  endtask

  // Hold reset for a cycle, release, then time the init sweep and peek the cleared memory.
  task automatic do_reset(input string pfx);
    int n;
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    @(posedge i_clk); #1;
    chk_zero({pfx, "_rst"});
    for (int k = 0; k < NS; k++) hist[k].delete();
    e_sid = '0; e_in = '0; e_out = '0; e_full = 1'b0; e_cnt = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge i_clk); #1;
      n++;
      if (o_ready === 1'b1) break;
      chk({pfx, "_init_valid"}, 64'(o_valid), 0);
    end
    chk({pfx, "_init_cycles"}, 64'(n), 64'(NS * B));
    for (int a = 0; a < NS * B; a++)
      chk($sformatf("%s_mem%0d", pfx, a), 64'(dut.mem[a]), 0);
    @(negedge i_clk);
  endtask

  // One cycle of stimulus applied at a falling edge; results checked just after the next rising edge.
  task automatic step(input logic v, input logic f, input logic [1:0] s, input logic [31:0] p);
    i_valid = v; i_flush = f; i_stock_id = s; i_price = p;
    e_valid = 1'b0;
    if (f && FLUSH_EN) begin
      hist[s].delete();
    end else if (v) begin
      hist[s].push_back(p);
      e_out = '0;
      if (hist[s].size() > B) e_out = hist[s].pop_front();
      e_valid = 1'b1;
      e_sid   = s;
      e_in    = p;
      e_cnt   = 3'(hist[s].size());
      e_full  = (hist[s].size() == B);
    end
    step_no++;
    @(posedge i_clk); #1;
    chk($sformatf("ready#%0d", step_no), 64'(o_ready), 1);
    chk($sformatf("valid#%0d", step_no), 64'(o_valid), 64'(e_valid));
    chk($sformatf("sid#%0d",   step_no), 64'(o_stock_id), 64'(e_sid));
    chk($sformatf("in#%0d",    step_no), 64'(o_incoming_price), 64'(e_in));
    chk($sformatf("out#%0d",   step_no), 64'(o_outgoing_price), 64'(e_out));
    chk($sformatf("full#%0d",  step_no), 64'(o_window_full), 64'(e_full));
    chk($sformatf("cnt#%0d",   step_no), 64'(o_count), 64'(e_cnt));
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  initial begin
    logic v, f;
    logic [1:0] s;

    do_reset("por");

    // Stock 1 fills then starts evicting.
    for (int k = 1; k <= 4; k++) step(1, 0, 2'd1, 32'(10 * k));
    chk("s1_full_at_40", 64'(o_window_full), 1);
    step(1, 0, 2'd1, 32'd50);
    chk("s1_evict_10", 64'(o_outgoing_price), 10);
    step(1, 0, 2'd1, 32'd60);
    chk("s1_evict_20", 64'(o_outgoing_price), 20);
    step(0, 0, 2'd1, 32'd0);
    chk("hold_in", 64'(o_incoming_price), 60);

    // Interleaved stocks 0 and 3, back to back.
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 2'd0, 32'(100 + k));
      if (k == 4) chk("s0_5th_out", 64'(o_outgoing_price), 100);
      step(1, 0, 2'd3, 32'(200 + k));
    end

    // Flush stock 2 after filling it.
    for (int k = 1; k <= 4; k++) step(1, 0, 2'd2, 32'(k));
    step(0, 1, 2'd2, 32'd0);
    step(1, 0, 2'd2, 32'd7);
`ifdef SMA_BUF_FLUSH_EN
    chk("flush_out", 64'(o_outgoing_price), 0);
    chk("flush_cnt", 64'(o_count), 1);
`else
    chk("noflush_out", 64'(o_outgoing_price), 1);
    chk("noflush_cnt", 64'(o_count), 4);
`endif
    step(1, 0, 2'd3, 32'd300);
    step(1, 0, 2'd1, 32'd70);

    // Valid and flush together on stock 0.
    step(1, 1, 2'd0, 32'd555);
    step(1, 0, 2'd0, 32'd9);

    // Random traffic.
    for (int k = 0; k < 80; k++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      s = 2'($urandom_range(0, NS - 1));
      step(v, f, s, $urandom);
    end

    // Reset while stock 1 is full and a result is pending.
    for (int k = 0; k < 4; k++) step(1, 0, 2'd1, 32'(40 + k));
    i_valid = 1'b1; i_stock_id = 2'd1; i_price = 32'd77;
    @(posedge i_clk); #1;
    chk("pending_valid", 64'(o_valid), 1);
    i_valid = 1'b0;
    #1 i_rst = 1'b1;
    #1 chk_zero("midrst");
    do_reset("midrst2");
    step(1, 0, 2'd1, 32'd88);
    chk("post_rst_out", 64'(o_outgoing_price), 0);
    chk("post_rst_cnt", 64'(o_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
